// File: rtl/irq_controller.sv
// irq_controller: 24-source edge-triggered interrupt controller.
// Each source is (optionally) synchronized, rising-edge detected into a
// pending register, qualified by a mask, and the lowest eligible index is
// offered to the processor through a req/ack/eoi handshake.
//
// Handshake: int_req stays high with int_vec stable until int_ack is seen
// (one-cycle pulse); the controller is then busy until an eoi pulse.
// int_ack outside the request phase and eoi outside service are ignored.
module irq_controller #(
  parameter int SYNC_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] irq,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [11:0] cfg_wdata,
  output logic [11:0] cfg_rdata,
  output logic        int_req,
  output logic [4:0]  int_vec,
  input  logic        int_ack,
  input  logic        eoi,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [23:0] irq_s;
  logic [23:0] prev_q;
  logic [23:0] rise;
  logic [23:0] mask_q, mask_d;
  logic [23:0] pending_q, pending_d;
  logic [23:0] clr;
  logic [23:0] elig;
  logic [4:0]  win_idx;
  logic        win_any;
  logic [1:0]  state_q, state_d;
  logic [4:0]  int_vec_q, int_vec_d;

  // Optional two-flop synchronizer; reset to ones so sources held high
  // through reset never look like a fresh edge.
  generate
    if (SYNC_EN != 0) begin : g_sync
      logic [23:0] sync1_q;
      logic [23:0] sync2_q;

      // Two-stage metastability filter on every source.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync1_q <= '1;
          sync2_q <= '1;
        end else begin
          sync1_q <= irq;
          sync2_q <= sync1_q;
        end
      end

      assign irq_s = sync2_q;
    end else begin : g_nosync
      assign irq_s = irq;
    end
  endgenerate

  // Previous-cycle copy of the (synchronized) sources for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '1;
    end else begin
      prev_q <= irq_s;
    end
  end

  assign rise = irq_s & ~prev_q;

  // Write-1-to-clear vector built from pending-register writes.
  always_comb begin
    clr = '0;
    if (cfg_we) begin
      if (cfg_addr == 2'd2) clr[11:0]  = cfg_wdata;
      if (cfg_addr == 2'd3) clr[23:12] = cfg_wdata;
    end
  end

  // Mask register next-state: each write loads one half.
  always_comb begin
    mask_d = mask_q;
    if (cfg_we) begin
      if (cfg_addr == 2'd0) mask_d[11:0]  = cfg_wdata;
      if (cfg_addr == 2'd1) mask_d[23:12] = cfg_wdata;
    end
  end

  // Pending next-state: clears first, new edges win over clears, and an
  // accepted request clears its own bit regardless of a same-cycle edge.
  always_comb begin
    pending_d = (pending_q & ~clr) | rise;
    if (state_q == ST_REQ && int_ack) begin
      pending_d[int_vec_q] = 1'b0;
    end
  end

  assign elig = pending_q & mask_q;

  // Fixed priority: the lowest eligible index wins.
  always_comb begin
    win_idx = 5'd0;
    win_any = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (elig[i] && !win_any) begin
        win_idx = 5'(i);
        win_any = 1'b1;
      end
    end
  end

  // Handshake FSM next-state and vector latch.
  always_comb begin
    state_d   = state_q;
    int_vec_d = int_vec_q;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          int_vec_d = win_idx;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (int_ack) state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (eoi) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register update for all controller state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      int_vec_q <= 5'd0;
      mask_q    <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      int_vec_q <= int_vec_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
    end
  end

  // Register readback mux.
  always_comb begin
    case (cfg_addr)
      2'd0:    cfg_rdata = mask_q[11:0];
      2'd1:    cfg_rdata = mask_q[23:12];
      2'd2:    cfg_rdata = pending_q[11:0];
      default: cfg_rdata = pending_q[23:12];
    endcase
  end

  assign int_req     = (state_q == ST_REQ);
  assign busy        = (state_q == ST_SERVICE);
  assign int_vec     = int_vec_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter SYNC_EN, default 1: when 1, each irq bit SHALL pass through a 2-flop synchronizer before edge detection; when 0, irq SHALL feed edge detection directly.
REQ-002 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 irq  in  24  interrupt sources; a rising edge requests service.
REQ-005 cfg_we  in  1  configuration write strobe.
REQ-006 cfg_addr  in  2  register select: 0 mask[11:0], 1 mask[23:12], 2 pending[11:0], 3 pending[23:12].
REQ-007 cfg_wdata  in  12  write data.
REQ-008 cfg_rdata  out  12  combinational read of the register selected by cfg_addr.
REQ-009 int_req  out  1  interrupt request to the processor.
REQ-010 int_vec  out  5  source index 0..23 of the requested interrupt.
REQ-011 int_ack  in  1  processor accepts the request; single-cycle pulse.
REQ-012 eoi  in  1  processor end-of-interrupt; single-cycle pulse.
REQ-013 busy  out  1  an interrupt is in service.

Function
REQ-014 Writes to cfg_addr 0/1 SHALL load the mask half; a mask bit of 1 enables its source.
REQ-015 Writes to cfg_addr 2/3 SHALL clear each pending bit whose cfg_wdata bit is 1 (write-1-to-clear); 0 bits SHALL leave pending unchanged.
REQ-016 An edge is a cycle where the (synchronized) irq bit is 1 and its previous-cycle registered value is 0; an edge SHALL set the pending bit regardless of mask.
REQ-017 An edge and a write-1-to-clear on the same bit in the same cycle: the set SHALL win.
REQ-018 Latency: SYNC_EN=0, irq first sampled high at edge k -> pending set after edge k, int_req high after edge k+1; SYNC_EN=1 -> pending after k+2, int_req after k+3.
REQ-019 Priority: the eligible set is pending & mask; the lowest index SHALL win.
REQ-020 FSM states IDLE, REQ, SERVICE.
REQ-021 IDLE: int_req=0, busy=0; if the eligible set is nonzero, the winner index SHALL be latched into int_vec and the FSM SHALL go to REQ.
REQ-022 REQ: int_req=1; int_vec SHALL stay stable until int_ack, even if a higher-priority source arrives or the latched source is masked or cleared.
REQ-023 REQ + int_ack: the pending bit at int_vec SHALL clear on that edge (overriding a same-cycle edge on that bit) and the FSM SHALL go to SERVICE.
REQ-024 SERVICE: int_req=0, busy=1, int_vec held; eoi SHALL return the FSM to IDLE. Nesting is not supported.
REQ-025 int_ack outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-026 After eoi, a remaining eligible source SHALL raise int_req no earlier than 1 cycle after the return to IDLE.
REQ-027 A source edge while its pending bit is already set SHALL be lost; there is no counting.

Reset
REQ-028 While rst=0: FSM=IDLE; mask=0; pending=0; int_req=0; int_vec=0; busy=0.
REQ-029 While rst=0, synchronizer and previous-value flops SHALL be all ones, so sources held high through reset do not create edges.
REQ-030 Reset asserted in REQ or SERVICE SHALL abandon the handshake immediately; no ack or eoi is required afterwards.

Verification
REQ-031 SYNC_EN=0, mask=0xFFFFFF, irq[5] rises at edge k -> int_req=1, int_vec=5 after k+1; int_ack -> busy=1, pending[5]=0; eoi -> IDLE.
REQ-032 irq[9] and irq[3] rise in the same cycle -> int_vec=3 first; after ack and eoi -> int_vec=9.
REQ-033 mask=0, irq[7] rises -> pending[11:0]=0x080, int_req stays 0; then write mask lo=0x080 -> int_req=1, int_vec=7.
REQ-034 In REQ with int_vec=10, irq[2] rises -> int_vec stays 10 until ack; after eoi -> int_vec=2.
REQ-035 irq[0] held high through reset release -> pending stays 0; write 0x001 to addr 2 in the same cycle as a new irq[0] edge -> pending[0]=1.
REQ-036 rst pulsed low in SERVICE -> busy=0, int_req=0, mask=0 immediately; a later eoi has no effect.
